// File: rtl/trap_commit_pkg.sv
// trap_commit_pkg: shared types, CSR addresses and mstatus bit positions for the commit stage.
package trap_commit_pkg;

    typedef enum logic [3:0] {
        EX_INSTR_ADDR_MISALIGNED = 4'd0,
        EX_INSTR_ACCESS_FAULT    = 4'd1,
        EX_ILLEGAL_INSTR         = 4'd2,
        EX_BREAKPOINT            = 4'd3,
        EX_LOAD_ADDR_MISALIGNED  = 4'd4,
        EX_LOAD_ACCESS_FAULT     = 4'd5,
        EX_STORE_ADDR_MISALIGNED = 4'd6,
        EX_STORE_ACCESS_FAULT    = 4'd7,
        EX_U_ECALL               = 4'd8,
        EX_M_ECALL               = 4'd11
    } ex_type_t;

    typedef struct packed {
        logic [4:0]  rd_idx;
        logic [31:0] rd_val;
        logic        br_valid;
        logic [31:0] br_target;
        logic        ex_valid;
        ex_type_t    ex;
        logic [31:0] ex_tval;
        logic        ret_valid;
    } exec_result_t;

    typedef enum logic {RUN, DRAIN} commit_state_t;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;

endpackage

// File: rtl/trap_commit_if.sv
// trap_commit_if: exec_result handshake from the exec units into the commit stage.
interface trap_commit_if;
    logic                         in_valid;
    logic                         in_ready;
    logic [31:0]                  in_pc;
    trap_commit_pkg::exec_result_t in_result;

    modport master(output in_valid, in_pc, in_result, input in_ready);
    modport slave(input in_valid, in_pc, in_result, output in_ready);
endinterface

// File: rtl/trap_commit_csr_file.sv
// trap_csr_file: M-mode trap CSRs with commit-over-software write arbitration.
// Optional minstret counter under TRAP_COMMIT_MINSTRET_EN.
module trap_csr_file
    import trap_commit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        trap,
    input  logic        mret,
`ifdef TRAP_COMMIT_MINSTRET_EN
    input  logic        retire,
    output logic [63:0] minstret,
`endif
    input  logic [31:0] trap_pc,
    input  ex_type_t    trap_ex,
    input  logic [31:0] trap_tval,
    input  logic        csr_we,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] mepc,
    output logic [31:0] mcause,
    output logic [31:0] mtval,
    output logic        mie,
    output logic        mpie
);

    logic we_mstatus, we_mepc, we_mcause, we_mtval;

    assign we_mstatus = csr_we && csr_addr == CSR_MSTATUS;
    assign we_mepc    = csr_we && csr_addr == CSR_MEPC;
    assign we_mcause  = csr_we && csr_addr == CSR_MCAUSE;
    assign we_mtval   = csr_we && csr_addr == CSR_MTVAL;

    // A trap owns every trap CSR this cycle; MRET only owns mstatus.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mepc   <= '0;
            mcause <= '0;
            mtval  <= '0;
            mie    <= 1'b0;
            mpie   <= 1'b0;
        end else begin
            if (trap) begin
                mepc   <= trap_pc;
                mcause <= {28'b0, trap_ex};
                mtval  <= trap_ex == EX_INSTR_ADDR_MISALIGNED ? trap_tval : '0;
                mpie   <= mie;
                mie    <= 1'b0;
            end else begin
                if (we_mepc) mepc <= {csr_wdata[31:2], 2'b00};
                if (we_mcause) mcause <= csr_wdata;
                if (we_mtval) mtval <= csr_wdata;
                if (mret) begin
                    mie  <= mpie;
                    mpie <= 1'b1;
                end else if (we_mstatus) begin
                    mie  <= csr_wdata[MSTATUS_MIE_BIT];
                    mpie <= csr_wdata[MSTATUS_MPIE_BIT];
                end
            end
        end
    end

`ifdef TRAP_COMMIT_MINSTRET_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) minstret <= '0;
        else if (csr_we && csr_addr == CSR_MINSTRET) minstret[31:0] <= csr_wdata;
        else if (csr_we && csr_addr == CSR_MINSTRETH) minstret[63:32] <= csr_wdata;
        else if (retire) minstret <= minstret + 64'd1;
    end
`endif

endmodule

// File: rtl/trap_commit.sv
// trap_commit: retires exec results, writes rd, redirects fetch on branch/trap/MRET, drains after redirects.
// Define TRAP_COMMIT_MINSTRET_EN to add the minstret counter output.
module trap_commit
    import trap_commit_pkg::*;
#(
    parameter logic [31:0] MTVEC_BASE   = 32'h0000_0100,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst,
    trap_commit_if.slave exec,
    output logic         wb_en,
    output logic [4:0]   wb_idx,
    output logic [31:0]  wb_val,
    output logic         redirect_valid,
    output logic [31:0]  redirect_pc,
    input  logic         csr_we,
    input  logic [11:0]  csr_addr,
    input  logic [31:0]  csr_wdata,
    output logic [31:0]  mepc,
    output logic [31:0]  mcause,
    output logic [31:0]  mtval,
`ifdef TRAP_COMMIT_MINSTRET_EN
    output logic [63:0]  minstret,
`endif
    output logic         mstatus_mie,
    output logic         mstatus_mpie
);

    localparam logic [3:0] FLUSH = 4'(FLUSH_CYCLES);

    commit_state_t state, state_next;
    logic [3:0]    cnt, cnt_next;
    exec_result_t  r;
    logic          accept, trap, mret, br, wr, redirect;
    logic [31:0]   target;

    assign r        = exec.in_result;
    assign accept   = exec.in_valid && exec.in_ready;
    assign trap     = accept && r.ex_valid;
    assign mret     = accept && !r.ex_valid && r.ret_valid;
    assign br       = accept && !r.ex_valid && !r.ret_valid && r.br_valid;
    assign wr       = accept && !r.ex_valid && !r.ret_valid && r.rd_idx != 5'd0;
    assign redirect = trap || mret || br;
    assign target   = trap ? MTVEC_BASE : mret ? mepc : r.br_target;

    always_comb begin
        state_next = state == RUN ? (redirect ? DRAIN : RUN) : (cnt == 4'd1 ? RUN : DRAIN);
        cnt_next   = state == RUN ? (redirect ? FLUSH : cnt) : cnt - 4'd1;
    end

    // in_ready is registered so it tracks the state it will be paired with.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= RUN;
            cnt           <= '0;
            exec.in_ready <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            exec.in_ready <= state_next == RUN;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_en          <= 1'b0;
            wb_idx         <= '0;
            wb_val         <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            wb_en          <= wr;
            redirect_valid <= redirect;
            if (wr) begin
                wb_idx <= r.rd_idx;
                wb_val <= r.rd_val;
            end
            if (redirect) redirect_pc <= target;
        end
    end

    trap_csr_file u_csr (
        .clk      (clk),
        .rst      (rst),
        .trap     (trap),
        .mret     (mret),
`ifdef TRAP_COMMIT_MINSTRET_EN
        .retire   (accept && !r.ex_valid),
        .minstret (minstret),
`endif
        .trap_pc  (exec.in_pc),
        .trap_ex  (r.ex),
        .trap_tval(r.ex_tval),
        .csr_we   (csr_we),
        .csr_addr (csr_addr),
        .csr_wdata(csr_wdata),
        .mepc     (mepc),
        .mcause   (mcause),
        .mtval    (mtval),
        .mie      (mstatus_mie),
        .mpie     (mstatus_mpie)
    );

endmodule

// File: tb/tb_trap_commit.sv
// tb_trap_commit: scoreboard bench for trap_commit; expected outputs are queued at drive time and popped after the edge.
module tb_trap_commit;
    import trap_commit_pkg::*;

    typedef struct packed {
        logic        wb_en;
        logic [4:0]  wb_idx;
        logic [31:0] wb_val;
        logic        rv;
        logic [31:0] rpc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        csr_we = 1'b0;
    logic [11:0] csr_addr = '0;
    logic [31:0] csr_wdata = '0;
    logic        wb_en, redirect_valid, mstatus_mie, mstatus_mpie;
    logic [4:0]  wb_idx;
    logic [31:0] wb_val, redirect_pc, mepc, mcause, mtval;
`ifdef TRAP_COMMIT_MINSTRET_EN
    logic [63:0] minstret;
    logic [63:0] m_inst = '0;
`endif

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    logic [4:0]  m_idx = '0;
    logic [31:0] m_val = '0, m_rpc = '0, m_mepc = '0, m_mcause = '0, m_mtval = '0;
    logic        m_mie = 1'b0, m_mpie = 1'b0;

    trap_commit_if bus();

    trap_commit dut (
        .clk           (clk),
        .rst           (rst),
        .exec          (bus),
        .wb_en         (wb_en),
        .wb_idx        (wb_idx),
        .wb_val        (wb_val),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .csr_we        (csr_we),
        .csr_addr      (csr_addr),
        .csr_wdata     (csr_wdata),
        .mepc          (mepc),
        .mcause        (mcause),
        .mtval         (mtval),
`ifdef TRAP_COMMIT_MINSTRET_EN
        .minstret      (minstret),
`endif
        .mstatus_mie   (mstatus_mie),
        .mstatus_mpie  (mstatus_mpie)
    );

    always #5 clk = ~clk;

    function automatic exp_t got_out();
        return {wb_en, wb_idx, wb_val, redirect_valid, redirect_pc};
    endfunction

    function automatic logic [97:0] got_csr();
        return {mepc, mcause, mtval, mstatus_mie, mstatus_mpie};
    endfunction

    function automatic logic [97:0] model_csr();
        return {m_mepc, m_mcause, m_mtval, m_mie, m_mpie};
    endfunction

    function automatic exec_result_t mk(input logic [4:0] rd, input logic [31:0] val, input logic br,
                                        input logic [31:0] tgt, input logic exv, input ex_type_t ex,
                                        input logic [31:0] tval, input logic ret);
        exec_result_t x;
        x.rd_idx = rd; x.rd_val = val; x.br_valid = br; x.br_target = tgt;
        x.ex_valid = exv; x.ex = ex; x.ex_tval = tval; x.ret_valid = ret;
        return x;
    endfunction

    // Drives one cycle of stimulus at the falling edge, predicts the registered outputs and CSRs.
    task automatic drive(input logic v, input logic [31:0] pc, input exec_result_t r,
                         input logic we, input logic [11:0] a, input logic [31:0] d);
        exp_t e;
        logic acc, tr, mr, brr, wr;
        @(negedge clk);
        bus.in_valid = v; bus.in_pc = pc; bus.in_result = r;
        csr_we = we; csr_addr = a; csr_wdata = d;
        acc = v && bus.in_ready;
        tr  = acc && r.ex_valid;
        mr  = acc && !r.ex_valid && r.ret_valid;
        brr = acc && !r.ex_valid && !r.ret_valid && r.br_valid;
        wr  = acc && !r.ex_valid && !r.ret_valid && r.rd_idx != 5'd0;
        if (wr) begin m_idx = r.rd_idx; m_val = r.rd_val; end
        if (tr) m_rpc = 32'h100; else if (mr) m_rpc = m_mepc; else if (brr) m_rpc = r.br_target;
        e = {wr, m_idx, m_val, tr || mr || brr, m_rpc};
        exp_q.push_back(e);
        if (tr) begin
            m_mepc = pc; m_mcause = {28'b0, r.ex};
            m_mtval = r.ex == EX_INSTR_ADDR_MISALIGNED ? r.ex_tval : 32'h0;
            m_mpie = m_mie; m_mie = 1'b0;
        end else begin
            if (we && a == 12'h341) m_mepc = {d[31:2], 2'b00};
            if (we && a == 12'h342) m_mcause = d;
            if (we && a == 12'h343) m_mtval = d;
            if (mr) begin m_mie = m_mpie; m_mpie = 1'b1; end
            else if (we && a == 12'h300) begin m_mie = d[3]; m_mpie = d[7]; end
        end
`ifdef TRAP_COMMIT_MINSTRET_EN
        if (acc && !r.ex_valid) m_inst = m_inst + 64'd1;
`endif
        @(posedge clk); #1;
        bus.in_valid = 1'b0; csr_we = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL wait_ready: in_ready=%b after %0d cycles, required 1", bus.in_ready, n);
        end
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_result = '0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({got_out(), bus.in_ready} !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h ready=%b, required all 0", got_out(), bus.in_ready);
        end
        checks++;
        if (got_csr() !== '0) begin
            errors++; $display("FAIL reset_csrs: got %h, required 0", got_csr());
        end
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release_ready: got %b, required 1", bus.in_ready);
        end
    endtask

    task automatic test_plain();
        exp_t e;
        drive(1'b1, 32'h10, mk(5'd5, 32'h1234, 1'b0, '0, 1'b0, EX_INSTR_ADDR_MISALIGNED, '0, 1'b0), 1'b0, '0, '0);
        e = exp_q.pop_front();
        checks++;
        if (got_out() !== e || {wb_en, wb_idx, wb_val, redirect_valid} !== {1'b1, 5'd5, 32'h1234, 1'b0}) begin
            errors++; $display("FAIL plain_wb: got %h, required %h", got_out(), e);
        end
        drive(1'b0, 32'h14, mk(5'd6, 32'h9999, 1'b1, 32'h40, 1'b1, EX_M_ECALL, '0, 1'b0), 1'b0, '0, '0);
        e = exp_q.pop_front();
        checks++;
        if (got_out() !== e) begin
            errors++; $display("FAIL idle_hold: got %h, required %h", got_out(), e);
        end
        drive(1'b1, 32'h18, mk(5'd0, 32'h7777, 1'b0, '0, 1'b0, EX_INSTR_ADDR_MISALIGNED, '0, 1'b0), 1'b0, '0, '0);
        e = exp_q.pop_front();
        checks++;
        if (got_out() !== e || wb_en !== 1'b0) begin
            errors++; $display("FAIL plain_rd0: got %h, required %h", got_out(), e);
        end
    endtask

    task automatic test_trap_misaligned();
        exp_t e;
        int n = 0;
        wait_ready();
        drive(1'b1, 32'h80, mk(5'd4, 32'h1, 1'b0, '0, 1'b1, EX_INSTR_ADDR_MISALIGNED, 32'h1002, 1'b0), 1'b0, '0, '0);
        e = exp_q.pop_front();
        checks++;
        if (got_out() !== e || redirect_pc !== 32'h100) begin
            errors++; $display("FAIL trap_redirect: got %h, required %h", got_out(), e);
        end
        checks++;
        if (got_csr() !== model_csr() || {mepc, mtval, mstatus_mie} !== {32'h80, 32'h1002, 1'b0}) begin
            errors++; $display("FAIL trap_csrs: got %h, required %h", got_csr(), model_csr());
        end
        while (bus.in_ready !== 1'b1 && n < 20) begin n++; @(posedge clk); #1; end
        checks++;
        if (n !== 2) begin
            errors++; $display("FAIL drain_len: in_ready low %0d cycles, required 2", n);
        end
    endtask

    task automatic test_mret();
        exp_t e;
        drive(1'b0, '0, '0, 1'b1, 12'h300, 32'h8);
        e = exp_q.pop_front();
        checks++;
        if (got_out() !== e || mstatus_mie !== 1'b1) begin
            errors++; $display("FAIL mstatus_write: got out %h mie=%b, required %h mie=1", got_out(), mstatus_mie, e);
        end
        drive(1'b1, 32'h24, mk(5'd1, '0, 1'b0, '0, 1'b1, EX_M_ECALL, 32'hdead, 1'b0), 1'b0, '0, '0);
        e = exp_q.pop_front();
        checks++;
        if (got_out() !== e || got_csr() !== model_csr() ||
            {mstatus_mpie, mstatus_mie, mtval, mcause} !== {1'b1, 1'b0, 32'h0, 32'd11}) begin
            errors++; $display("FAIL ecall_trap: got %h/%h, required %h/%h", got_out(), got_csr(), e, model_csr());
        end
        wait_ready();
        drive(1'b0, '0, '0, 1'b1, 12'h341, 32'h84);
        void'(exp_q.pop_front());
        drive(1'b1, 32'h100, mk(5'd3, '0, 1'b0, '0, 1'b0, EX_INSTR_ADDR_MISALIGNED, '0, 1'b1), 1'b0, '0, '0);
        e = exp_q.pop_front();
        checks++;
        if (got_out() !== e || got_csr() !== model_csr() ||
            {redirect_pc, wb_en, mstatus_mie, mstatus_mpie} !== {32'h84, 1'b0, 1'b1, 1'b1}) begin
            errors++; $display("FAIL mret: got %h/%h, required %h/%h", got_out(), got_csr(), e, model_csr());
        end
    endtask

    task automatic test_branch();
        exp_t e;
        wait_ready();
        drive(1'b1, 32'h200, mk(5'd0, 32'hdead, 1'b1, 32'h2000, 1'b0, EX_INSTR_ADDR_MISALIGNED, '0, 1'b0), 1'b0, '0, '0);
        e = exp_q.pop_front();
        checks++;
        if (got_out() !== e || {wb_en, redirect_valid, redirect_pc} !== {1'b0, 1'b1, 32'h2000}) begin
            errors++; $display("FAIL jalr_rd0: got %h, required %h", got_out(), e);
        end
        wait_ready();
        drive(1'b1, 32'h2000, mk(5'd3, 32'h2004, 1'b1, 32'h3000, 1'b0, EX_INSTR_ADDR_MISALIGNED, '0, 1'b0), 1'b0, '0, '0);
        e = exp_q.pop_front();
        checks++;
        if (got_out() !== e) begin
            errors++; $display("FAIL jal_rd3: got %h, required %h", got_out(), e);
        end
        wait_ready();
        drive(1'b1, 32'h3000, mk(5'd7, 32'h55, 1'b1, 32'h4000, 1'b1, EX_ILLEGAL_INSTR, 32'h77, 1'b0), 1'b0, '0, '0);
        e = exp_q.pop_front();
        checks++;
        if (got_out() !== e || got_csr() !== model_csr() || {wb_en, redirect_pc} !== {1'b0, 32'h100}) begin
            errors++; $display("FAIL ex_over_br: got %h/%h, required %h/%h", got_out(), got_csr(), e, model_csr());
        end
    endtask

    task automatic test_csr_collision();
        exp_t e;
        wait_ready();
        drive(1'b1, 32'h40, mk(5'd2, '0, 1'b0, '0, 1'b1, EX_BREAKPOINT, '0, 1'b0), 1'b1, 12'h341, 32'h555);
        e = exp_q.pop_front();
        checks++;
        if (got_out() !== e || got_csr() !== model_csr() || mepc !== 32'h40) begin
            errors++; $display("FAIL trap_vs_csr: mepc=%h, required 40 (%h)", mepc, model_csr());
        end
        wait_ready();
        drive(1'b0, '0, '0, 1'b1, 12'h341, 32'h555);
        void'(exp_q.pop_front());
        checks++;
        if (mepc !== 32'h554) begin
            errors++; $display("FAIL mepc_align: got %h, required 554", mepc);
        end
        drive(1'b1, 32'h60, mk(5'd0, '0, 1'b0, '0, 1'b0, EX_INSTR_ADDR_MISALIGNED, '0, 1'b1), 1'b1, 12'h341, 32'h200);
        e = exp_q.pop_front();
        checks++;
        if (got_out() !== e || got_csr() !== model_csr() || {redirect_pc, mepc} !== {32'h554, 32'h200}) begin
            errors++; $display("FAIL mret_vs_csr: got %h/%h, required %h/%h", got_out(), got_csr(), e, model_csr());
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        wait_ready();
        for (int i = 0; i < 12; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom, mk(5'($urandom_range(0, 31)), $urandom, 1'b0, '0, 1'b0,
                  EX_INSTR_ADDR_MISALIGNED, '0, 1'b0), 1'b0, '0, '0);
            e = exp_q.pop_front();
            checks++;
            if (got_out() !== e || bus.in_ready !== 1'b1) begin
                errors++; $display("FAIL b2b[%0d]: got %h ready=%b, required %h ready=1", i, got_out(), bus.in_ready, e);
            end
        end
`ifdef TRAP_COMMIT_MINSTRET_EN
        checks++;
        if (minstret !== m_inst) begin
            errors++; $display("FAIL minstret: got %0d, required %0d", minstret, m_inst);
        end
`endif
    endtask

    task automatic test_reset_drain();
        wait_ready();
        drive(1'b1, 32'h500, mk(5'd9, 32'habcd, 1'b1, 32'h3000, 1'b0, EX_INSTR_ADDR_MISALIGNED, '0, 1'b0), 1'b0, '0, '0);
        void'(exp_q.pop_front());
        @(posedge clk); #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL drain_before_reset: ready=%b, required 0", bus.in_ready);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({got_out(), bus.in_ready, got_csr()} !== '0) begin
            errors++; $display("FAIL async_reset: got %h ready=%b csr=%h, required all 0", got_out(), bus.in_ready, got_csr());
        end
        m_idx = '0; m_val = '0; m_rpc = '0; m_mepc = '0; m_mcause = '0; m_mtval = '0; m_mie = 1'b0; m_mpie = 1'b0;
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({bus.in_ready, redirect_valid, wb_en} !== 3'b100) begin
            errors++; $display("FAIL reset_drain_release: ready=%b rv=%b wb=%b, required 1 0 0", bus.in_ready, redirect_valid, wb_en);
        end
    endtask

    initial begin
        test_reset();
        test_plain();
        test_trap_misaligned();
        test_mret();
        test_branch();
        test_csr_collision();
        test_back_to_back();
        test_reset_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
